// File: rtl/char_sequencer.sv
// char_sequencer
//   Steps a 2-bit character code through 00 -> 01 -> 10 at a programmable rate.
//   C feeds the downstream character decoder/multiplexer stage.
//   Controls cover pause/hold, single-step, direction, speed and blanking.
// Ports
//   CLOCK_50  in   system clock, rising edge
//   KEY[3:0]  in   KEY[0] async active-low reset, KEY[1] step button (active-low)
//   SW[9:0]   in   SW[0] hold, SW[1] reverse, SW[2] blank, SW[9:8] speed
//   C[1:0]    out  character code (11 = blank)
//   LEDR[9:0] out  [9] hold state, [8] reverse, [7:0] wrap count
module char_sequencer #(
   parameter int unsigned TICK_DIV = 50_000_000
) (
   input  logic       CLOCK_50,
   input  logic [3:0] KEY,
   input  logic [9:0] SW,
   output logic [1:0] C,
   output logic [9:0] LEDR
);

   localparam int unsigned CntW = $clog2(TICK_DIV + 1);
   localparam logic [CntW-1:0] Div = CntW'(TICK_DIV);

   typedef enum logic {StRun, StHold} state_e;

   logic            w_rst_n;
   logic            w_unused;

   logic            r_key_meta;
   logic            r_key_sync;
   logic            r_key_prev;
   logic [4:0]      r_sw_meta;   // {speed[1:0], blank, reverse, hold}
   logic [4:0]      r_sw_sync;

   logic            w_hold;
   logic            w_rev;
   logic            w_blank;
   logic [1:0]      w_speed;
   logic            w_step;

   state_e          r_state;
   state_e          w_state_next;

   logic [CntW-1:0] r_cnt;
   logic [CntW-1:0] w_cnt_next;
   logic [CntW-1:0] w_period;
   logic [CntW-1:0] w_period_m1;
   logic            w_tick;
   logic            w_advance;
   logic            w_cnt_run;

   logic [1:0]      r_pos;
   logic [1:0]      w_pos_next;
   logic [7:0]      r_wrap;
   logic [7:0]      w_wrap_next;

   assign w_rst_n  = KEY[0];
   assign w_unused = ^{KEY[3:2], SW[7:3]};

   // Two-flop synchronizers; step button idles high, switches idle low.
   always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_key_meta <= 1'b1;
         r_key_sync <= 1'b1;
         r_key_prev <= 1'b1;
         r_sw_meta  <= '0;
         r_sw_sync  <= '0;
      end else begin
         r_key_meta <= KEY[1];
         r_key_sync <= r_key_meta;
         r_key_prev <= r_key_sync;
         r_sw_meta  <= {SW[9:8], SW[2:0]};
         r_sw_sync  <= r_sw_meta;
      end
   end

   assign w_hold  = r_sw_sync[0];
   assign w_rev   = r_sw_sync[1];
   assign w_blank = r_sw_sync[2];
   assign w_speed = r_sw_sync[4:3];

   // Press = falling edge of the synced button.
   assign w_step = r_key_prev & ~r_key_sync;

   assign w_period    = Div >> w_speed;
   assign w_period_m1 = w_period - CntW'(1);

   // FSM state register
   always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state <= StRun;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next state
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StRun:   if (w_hold)  w_state_next = StHold;
         StHold:  if (!w_hold) w_state_next = StRun;
         default: w_state_next = StRun;
      endcase
   end

   // FSM outputs. The >= compare lets a speed-up mid-count tick immediately.
   always_comb begin
      w_tick    = 1'b0;
      w_advance = 1'b0;
      w_cnt_run = 1'b0;
      unique case (r_state)
         StRun: begin
            w_tick    = (r_cnt >= w_period_m1);
            w_advance = w_tick;
            w_cnt_run = !w_hold;
         end
         StHold: begin
            // A step arriving as hold drops is discarded.
            w_advance = w_step & w_hold;
         end
         default: ;
      endcase
   end

   // Datapath next state
   always_comb begin
      w_cnt_next  = '0;
      w_pos_next  = r_pos;
      w_wrap_next = r_wrap;
      if (w_cnt_run && !w_tick) begin
         w_cnt_next = r_cnt + CntW'(1);
      end
      if (w_advance) begin
         if (w_rev) begin
            if (r_pos == 2'd0) begin
               w_pos_next  = 2'd2;
               w_wrap_next = r_wrap + 8'd1;
            end else begin
               w_pos_next = r_pos - 2'd1;
            end
         end else begin
            if (r_pos == 2'd2) begin
               w_pos_next  = 2'd0;
               w_wrap_next = r_wrap + 8'd1;
            end else begin
               w_pos_next = r_pos + 2'd1;
            end
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_cnt  <= '0;
         r_pos  <= 2'd0;
         r_wrap <= 8'd0;
      end else begin
         r_cnt  <= w_cnt_next;
         r_pos  <= w_pos_next;
         r_wrap <= w_wrap_next;
      end
   end

   // Outputs are driven from registers only.
   assign C    = w_blank ? 2'b11 : r_pos;
   assign LEDR = {(r_state == StHold), w_rev, r_wrap};

endmodule

// File: tb/tb_char_sequencer.sv
// Randomised bench for char_sequencer against a behavioural reference model.
module tb_char_sequencer;

   localparam int unsigned TickDiv = 8;

   logic       clk = 1'b0;
   logic [3:0] key;
   logic [9:0] sw;
   logic [1:0] c;
   logic [9:0] ledr;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: synced input views plus abstract sequencer state.
   int       m_pos;
   int       m_wrap;
   int       m_elapsed;   // run cycles since last tick or (re)start
   bit       m_held;
   bit       m_key_m, m_key_s, m_key_p;
   bit [4:0] m_sw_m, m_sw_s;

   char_sequencer #(.TICK_DIV(TickDiv)) dut (
      .CLOCK_50 (clk),
      .KEY      (key),
      .SW       (sw),
      .C        (c),
      .LEDR     (ledr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pos     = 0;
      m_wrap    = 0;
      m_elapsed = 0;
      m_held    = 1'b0;
      m_key_m   = 1'b1;
      m_key_s   = 1'b1;
      m_key_p   = 1'b1;
      m_sw_m    = '0;
      m_sw_s    = '0;
   endtask

   // One clock edge: decide from the synced view, then shift in raw inputs.
   task automatic model_step();
      int period;
      bit step, tick, adv, wrapped;
      period  = int'(TickDiv) >> m_sw_s[4:3];
      step    = m_key_p && !m_key_s;
      tick    = !m_held && (m_elapsed >= period - 1);
      adv     = tick || (m_held && m_sw_s[0] && step);
      wrapped = 1'b0;
      if (adv) begin
         if (m_sw_s[1]) begin
            wrapped = (m_pos == 0);
            m_pos   = (m_pos + 2) % 3;
         end else begin
            wrapped = (m_pos == 2);
            m_pos   = (m_pos + 1) % 3;
         end
         if (wrapped) m_wrap = (m_wrap + 1) % 256;
      end
      if (!m_held && !m_sw_s[0]) m_elapsed = tick ? 0 : m_elapsed + 1;
      else                       m_elapsed = 0;
      m_held  = m_sw_s[0];
      m_key_p = m_key_s;
      m_key_s = m_key_m;
      m_key_m = key[1];
      m_sw_s  = m_sw_m;
      m_sw_m  = {sw[9:8], sw[2:0]};
   endtask

   task automatic check_outputs();
      int exp_c, exp_led;
      exp_c   = m_sw_s[2] ? 3 : m_pos;
      exp_led = (int'(m_held) << 9) | (int'(m_sw_s[1]) << 8) | m_wrap;
      check("C", int'(c), exp_c);
      check("LEDR", int'(ledr), exp_led);
   endtask

   task automatic run_cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) run_cycle();
   endtask

   // Called at a negedge; reset must clear outputs with no clock edge.
   task automatic async_reset();
      #2;
      key[0] = 1'b0;
      #1;
      check("rst_async_C", int'(c), 0);
      check("rst_async_LEDR", int'(ledr), 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      check("rst_held_C", int'(c), 0);
      check("rst_held_LEDR", int'(ledr), 0);
      key[0] = 1'b1;
   endtask

   initial begin
      key = 4'b1110;
      sw  = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_C", int'(c), 0);
      check("reset_LEDR", int'(ledr), 0);
      key[0] = 1'b1;

      // Free-run forward
      run_cycles(25);
      // Reverse
      sw[1] = 1'b1;
      run_cycles(30);
      // Fastest rate, forward
      sw = 10'b11_0000_0000;
      run_cycles(12);
      // Hold with a single press
      sw = 10'b00_0000_0001;
      run_cycles(50);
      key[1] = 1'b0;
      run_cycles(5);
      key[1] = 1'b1;
      run_cycles(10);
      // Blank across ticks, then release
      sw = 10'b00_0000_0100;
      run_cycles(20);
      sw = '0;
      run_cycles(6);
      // Reset mid-count
      async_reset();
      run_cycles(10);

      // Random phases
      for (int ph = 0; ph < 150; ph++) begin
         int len, press_at, press_len;
         sw[0]   = ($urandom_range(0, 2) == 0);
         sw[1]   = $urandom_range(0, 1);
         sw[2]   = ($urandom_range(0, 3) == 0);
         sw[7:3] = 5'($urandom);
         sw[9:8] = 2'($urandom);
         key[3:2] = 2'($urandom);
         len       = $urandom_range(1, 30);
         press_at  = $urandom_range(0, len - 1);
         press_len = $urandom_range(1, 6);
         for (int i = 0; i < len; i++) begin
            key[1] = !((i >= press_at) && (i < press_at + press_len));
            run_cycle();
         end
         if (ph % 50 == 49) async_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
